// File: rtl/rf_wb_scheduler.sv
// Write-port scheduler for the single-write-port register file: round-robin writeback
// arbitration, registered write stage and per-register busy scoreboard for decode hazards.
module rf_wb_scheduler #(
   parameter int unsigned NUM_REQ  = 3,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_dest,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      alloc_en,
   input  logic [ADDR_W-1:0]         alloc_dest,
   input  logic [ADDR_W-1:0]         chk_src1,
   input  logic [ADDR_W-1:0]         chk_src2,
   output logic                      hazard,
   output logic [NUM_REGS-1:0]       busy_vec,
   output logic                      rf_writeEn,
   output logic [ADDR_W-1:0]         rf_dest,
   output logic [DATA_W-1:0]         rf_writeVal,
   output logic                      sb_err
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   logic [ADDR_W-1:0]   dest_arr [NUM_REQ];
   logic [DATA_W-1:0]   data_arr [NUM_REQ];

   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    cand;
   logic [PTR_W-1:0]    grant_idx;
   logic [NUM_REQ-1:0]  grant;
   logic                grant_found;
   logic                accept;
   logic [NUM_REGS-1:0] busy_d;
   logic                dbl_alloc;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign dest_arr[g] = req_dest[g*ADDR_W +: ADDR_W];
      assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
   end

   // Scan requesters starting at rr_ptr, wrapping; first valid one wins.
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = rr_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && req_valid[cand]) begin
            grant_found  = 1'b1;
            grant[cand]  = 1'b1;
            grant_idx    = cand;
         end
         cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      end
   end

   assign req_ready = rst ? '0 : grant;
   assign accept    = grant_found & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr      <= '0;
         rf_writeEn  <= 1'b0;
         rf_dest     <= '0;
         rf_writeVal <= '0;
      end else begin
         rf_writeEn <= accept;
         if (accept) begin
            rr_ptr      <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            rf_dest     <= dest_arr[grant_idx];
            rf_writeVal <= data_arr[grant_idx];
         end
      end
   end

   // Clear at the RF write edge, then set; a same-edge alloc overrides the clear.
   always_comb begin
      busy_d = busy_vec;
      if (rf_writeEn) begin
         busy_d[rf_dest] = 1'b0;
      end
      if (alloc_en) begin
         busy_d[alloc_dest] = 1'b1;
      end
   end

   assign dbl_alloc = alloc_en & busy_vec[alloc_dest]
                      & ~(rf_writeEn & (rf_dest == alloc_dest));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_vec <= '0;
         sb_err   <= 1'b0;
      end else begin
         busy_vec <= busy_d;
         if (dbl_alloc) begin
            sb_err <= 1'b1;
         end
      end
   end

   assign hazard = busy_vec[chk_src1] | busy_vec[chk_src2];

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: directed scenarios then random traffic, all checked against
// a cycle-level reference model of arbitration, write stage and scoreboard.
module tb_rf_wb_scheduler;

   logic         clk;
   logic         rst;
   logic [2:0]   req_valid;
   logic [14:0]  req_dest;
   logic [95:0]  req_data;
   logic [2:0]   req_ready;
   logic         alloc_en;
   logic [4:0]   alloc_dest;
   logic [4:0]   chk_src1;
   logic [4:0]   chk_src2;
   logic         hazard;
   logic [31:0]  busy_vec;
   logic         rf_writeEn;
   logic [4:0]   rf_dest;
   logic [31:0]  rf_writeVal;
   logic         sb_err;

   rf_wb_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_dest    (req_dest),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .alloc_en    (alloc_en),
      .alloc_dest  (alloc_dest),
      .chk_src1    (chk_src1),
      .chk_src2    (chk_src2),
      .hazard      (hazard),
      .busy_vec    (busy_vec),
      .rf_writeEn  (rf_writeEn),
      .rf_dest     (rf_dest),
      .rf_writeVal (rf_writeVal),
      .sb_err      (sb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model state
   int          m_ptr;
   logic [31:0] m_busy;
   logic        m_wen;
   logic [4:0]  m_dest;
   logic [31:0] m_val;
   logic        m_err;

   int   last_g;
   logic obs_hazard;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_busy = '0;
      m_wen  = 1'b0;
      m_dest = '0;
      m_val  = '0;
      m_err  = 1'b0;
   endtask

   // One clock: inputs already driven; check combinational outputs mid-cycle,
   // advance the model, then check registered outputs just after the edge.
   task automatic cycle();
      int          g;
      int          i;
      logic [2:0]  exp_ready;
      logic [31:0] n_busy;
      #2;
      g = -1;
      for (int k = 0; k < 3; k++) begin
         i = (m_ptr + k) % 3;
         if (g < 0 && req_valid[i]) g = i;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
      chk("hazard", hazard, m_busy[chk_src1] | m_busy[chk_src2]);
      obs_hazard = hazard;
      last_g     = g;

      n_busy = m_busy;
      if (m_wen) n_busy[m_dest] = 1'b0;
      if (alloc_en) n_busy[alloc_dest] = 1'b1;
      if (alloc_en && m_busy[alloc_dest] && !(m_wen && m_dest == alloc_dest)) m_err = 1'b1;
      m_busy = n_busy;
      if (g >= 0) begin
         m_wen  = 1'b1;
         m_dest = req_dest[g*5 +: 5];
         m_val  = req_data[g*32 +: 32];
         m_ptr  = (g + 1) % 3;
      end else begin
         m_wen = 1'b0;
      end

      @(posedge clk);
      #1;
      chk("rf_writeEn", rf_writeEn, m_wen);
      chk("rf_dest", rf_dest, m_dest);
      chk("rf_writeVal", rf_writeVal, m_val);
      chk("busy_vec", busy_vec, m_busy);
      chk("sb_err", sb_err, m_err);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_dest   = '0;
      req_data   = '0;
      alloc_en   = 1'b0;
      alloc_dest = '0;
      chk_src1   = '0;
      chk_src2   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_wen", rf_writeEn, 1'b0);
      chk("reset_busy", busy_vec, 32'h0);
      rst = 1'b0;

      // Round-robin with all requesters valid
      req_valid = 3'b111;
      req_dest  = {5'd3, 5'd2, 5'd1};
      req_data  = {32'hC000_0003, 32'hB000_0002, 32'hA000_0001};
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk("rr_grant", last_g, k % 3);
         chk("rr_dest", rf_dest, (k % 3) + 1);
      end

      // Idle, then lone req2, then all valid
      req_valid = 3'b000;
      cycle();
      req_valid = 3'b100;
      req_dest[14:10] = 5'd7;
      req_data[95:64] = 32'hDEAD_BEEF;
      cycle();
      chk("lone_grant", last_g, 2);
      chk("lone_dest", rf_dest, 5'd7);
      chk("lone_data", rf_writeVal, 32'hDEAD_BEEF);
      req_valid = 3'b111;
      cycle();
      chk("after_idle_grant", last_g, 0);

      // Scoreboard set/clear timing on r5
      req_valid  = 3'b000;
      alloc_en   = 1'b1;
      alloc_dest = 5'd5;
      cycle();
      alloc_en = 1'b0;
      chk_src1 = 5'd5;
      chk_src2 = 5'd0;
      cycle();
      chk("hazard_r5", obs_hazard, 1'b1);
      req_valid      = 3'b010;
      req_dest[9:5]  = 5'd5;
      cycle();
      req_valid = 3'b000;
      cycle();
      chk("hazard_n1", obs_hazard, 1'b1);
      chk("busy5_cleared", busy_vec[5], 1'b0);
      cycle();
      chk("hazard_n2", obs_hazard, 1'b0);

      // Same-edge alloc and clear of r9, first idle then already busy
      for (int k = 0; k < 2; k++) begin
         req_valid     = 3'b001;
         req_dest[4:0] = 5'd9;
         cycle();
         req_valid  = 3'b000;
         alloc_en   = 1'b1;
         alloc_dest = 5'd9;
         cycle();
         alloc_en = 1'b0;
         chk("collide_busy9", busy_vec[9], 1'b1);
         chk("collide_err", sb_err, 1'b0);
      end

      // Double alloc of r4, then writeback to idle r12
      alloc_en   = 1'b1;
      alloc_dest = 5'd4;
      cycle();
      cycle();
      chk("dbl_err", sb_err, 1'b1);
      alloc_en = 1'b0;
      cycle();
      cycle();
      chk("dbl_err_sticky", sb_err, 1'b1);
      chk("dbl_busy4", busy_vec[4], 1'b1);
      req_valid       = 3'b010;
      req_dest[9:5]   = 5'd12;
      req_data[63:32] = 32'h1234_5678;
      cycle();
      chk("wb12_wen", rf_writeEn, 1'b1);
      chk("wb12_dest", rf_dest, 5'd12);
      chk("wb12_data", rf_writeVal, 32'h1234_5678);
      req_valid = 3'b000;
      cycle();
      chk("wb12_busy", busy_vec[12], 1'b0);

      // Asynchronous reset mid-burst
      req_valid  = 3'b111;
      alloc_en   = 1'b1;
      alloc_dest = 5'd20;
      chk_src1   = 5'd20;
      cycle();
      cycle();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_wen", rf_writeEn, 1'b0);
      chk("rst_dest", rf_dest, 5'd0);
      chk("rst_val", rf_writeVal, 32'h0);
      chk("rst_busy", busy_vec, 32'h0);
      chk("rst_err", sb_err, 1'b0);
      chk("rst_ready", req_ready, 3'b000);
      chk("rst_hazard", hazard, 1'b0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      alloc_en = 1'b0;
      model_reset();
      cycle();
      chk("post_rst_grant", last_g, 0);

      // Random traffic; requesters hold until accepted
      req_valid = 3'b000;
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 3; i++) begin
            if (!req_valid[i] && ($urandom % 3 == 0)) begin
               req_valid[i]        = 1'b1;
               req_dest[i*5 +: 5]  = 5'($urandom_range(7));
               req_data[i*32 +: 32] = $urandom;
            end
         end
         alloc_en   = ($urandom % 4 == 0);
         alloc_dest = 5'($urandom_range(7));
         chk_src1   = 5'($urandom_range(7));
         chk_src2   = 5'($urandom_range(7));
         cycle();
         if (last_g >= 0) req_valid[last_g] = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
